// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// kills stale responses after a redirect and skids one response while decode stalls.
module fetch_ctrl #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      INCR     = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  output logic [WIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [WIDTH-1:0] INCR_W     = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(INCR_W - WIDTH'(1));

  state_t           state;
  logic             kill;
  logic [WIDTH-1:0] req_pc;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_pc;

  logic             consume;
  logic             resp_live;
  logic             resp_direct;
  logic [WIDTH-1:0] redirect_target;

  assign imem_req_o      = (state == S_REQ);
  assign imem_addr_o     = pc_o;
  assign consume         = instr_valid_o & ~stall_i;
  // A response is only useful if it is not stale and no redirect discards it this cycle.
  assign resp_live       = (state == S_WAIT) & imem_rvalid_i & ~kill & ~redirect_i;
  assign resp_direct     = ~instr_valid_o | consume;
  assign redirect_target = redirect_pc_i & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc_o          <= RESET_PC;
      kill          <= 1'b0;
      req_pc        <= '0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_pc       <= '0;
    end else begin
      if (redirect_i) begin
        instr_valid_o <= 1'b0;
        skid_valid    <= 1'b0;
      end else if (resp_live && resp_direct) begin
        instr_o       <= imem_rdata_i;
        instr_pc_o    <= req_pc;
        instr_valid_o <= 1'b1;
      end else begin
        if (resp_live) begin
          skid_valid <= 1'b1;
          skid_data  <= imem_rdata_i;
          skid_pc    <= req_pc;
        end
        if (consume) begin
          if (skid_valid) begin
            instr_o    <= skid_data;
            instr_pc_o <= skid_pc;
            skid_valid <= 1'b0;
          end else begin
            instr_valid_o <= 1'b0;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (redirect_i) begin
            pc_o  <= redirect_target;
            state <= S_REQ;
          end else if (!skid_valid) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_gnt_i) begin
            req_pc <= pc_o;
            state  <= S_WAIT;
            if (redirect_i) begin
              pc_o <= redirect_target;
              kill <= 1'b1;
            end else begin
              pc_o <= pc_o + INCR_W;
            end
          end else if (redirect_i) begin
            pc_o <= redirect_target;
          end
        end
        S_WAIT: begin
          if (redirect_i) pc_o <= redirect_target;
          // A response that went to the skid leaves us idle until decode drains it.
          if (imem_rvalid_i) begin
            kill <= 1'b0;
            if (kill || redirect_i || resp_direct) state <= S_REQ;
            else                                   state <= S_IDLE;
          end else if (redirect_i) begin
            kill <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and drives the instruction-memory request port. It issues one sequential fetch at a time (PC += INCR), applies branch/jump redirects from execute, and presents fetched instructions to decode with a valid/stall handshake. Stale responses from before a redirect are killed. A one-entry skid buffer absorbs a response that arrives while decode is stalled.

Parameters:
WIDTH, 32, address/instruction width
INCR, 4, sequential PC increment in bytes
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  decode cannot accept an instruction this cycle
redirect_i  in  1  take branch/jump this cycle
redirect_pc_i  in  WIDTH  redirect target
imem_req_o  out  1  fetch request valid
imem_addr_o  out  WIDTH  fetch address; equals pc_o
imem_gnt_i  in  1  request accepted this cycle (only meaningful when imem_req_o=1)
imem_rvalid_i  in  1  response data valid, one cycle, at least 1 cycle after gnt
imem_rdata_i  in  WIDTH  fetched instruction
instr_valid_o  out  1  instr_o/instr_pc_o valid for decode
instr_o  out  WIDTH  instruction to decode
instr_pc_o  out  WIDTH  address of instr_o
pc_o  out  WIDTH  next fetch address

Behaviour:
- Reset (rst=1 at an edge): pc_o=RESET_PC; state=IDLE; imem_req_o=0; instr_valid_o=0; instr_o=0; instr_pc_o=0; skid empty; kill=0; req_pc=0. rst overrides every other input, including mid-WAIT. A response arriving after reset for a pre-reset request is not a legal memory behaviour and is not handled.
- States: IDLE (req=0), REQ (req=1), WAIT (one outstanding, req=0). imem_req_o is decoded from state only.
- Handshake: consume = instr_valid_o & ~stall_i.
- IDLE -> REQ when the skid buffer is empty. After reset release, imem_req_o rises in the second cycle with rst=0.
- In REQ:
  - imem_addr_o = pc_o.
  - The address may change while gnt=0, but only on redirect.
  - On gnt: req_pc <= pc_o; pc_o <= pc_o + INCR, modulo 2^WIDTH, so 0xFFFFFFFC wraps to 0x0. Go to WAIT.
- In WAIT, on rvalid:
  - If kill=1: drop the data, clear kill, go to REQ.
  - Otherwise: if the output register is empty or consume=1, load instr_o=rdata and instr_pc_o=req_pc, and set instr_valid_o=1. Else write rdata/req_pc into the skid buffer.
  - Next state is REQ if the skid is empty after this edge, else IDLE.
- Output register:
  - On consume, refill from the skid if it is full (skid -> empty), else clear instr_valid_o.
  - instr_o/instr_pc_o stay stable while instr_valid_o & stall_i.
- Redirect (priority over stall and sequential update):
  - pc_o <= redirect_pc_i with the low log2(INCR) bits cleared.
  - instr_valid_o <= 0 and skid <= empty on the same edge.
  - In IDLE: go to REQ.
  - In REQ without gnt: stay in REQ; the new address appears the next cycle.
  - In REQ with gnt the same cycle: the accepted request is stale, so go to WAIT with kill=1.
  - In WAIT without rvalid: set kill=1 and stay in WAIT.
  - In WAIT with rvalid the same cycle: drop the response (kill stays 0) and go to REQ.
  - A redirect while kill=1 keeps kill=1.
- Throughput: at most one outstanding request. Best case is one instruction per 2 cycles (REQ gnt, WAIT rvalid).
- Invariant: the skid is never full while in REQ or WAIT, so data is never lost.

Test Plan:
- Sequential fetch: RESET_PC=0, gnt immediate, rvalid 1 cycle after gnt, stall_i=0 -> imem_addr_o 0x0, 0x4, 0x8 in successive REQ cycles; instr_pc_o 0x0, 0x4, 0x8 paired with the matching rdata.
- Stall/skid: hold stall_i=1 while instr 0x0 is valid and the response for 0x4 arrives -> instr_o is held at 0x0's data; 0x4 goes to the skid; imem_req_o stays 0. Release stall -> 0x4 is presented next cycle, then imem_req_o rises for 0x8.
- Redirect in WAIT: request to 0x8 is outstanding; redirect_i=1, redirect_pc_i=0x100 -> instr_valid_o drops; 0x8's response is dropped; the next request address is 0x100; the next instr_pc_o is 0x100.
- Redirect coincident with gnt: REQ 0x10 granted in the same cycle as redirect to 0x202 -> 0x10's response is killed; the next imem_addr_o is 0x200 (low bits cleared).
- Wrap: redirect to 0xFFFFFFFC, sequential fetch -> the following address is 0x00000000.
- Reset mid-operation: assert rst in WAIT with kill=1 and the skid full -> next cycle all outputs are at reset values; imem_req_o rises in the second cycle after rst is released, with address RESET_PC.
